lsu_dmem_port: RTL
==================

Name: lsu_dmem_port

Overview:
- Initiator side of the CPU data-memory port: the load/store unit between the execute stage and the dmem responder.
- Accepts one load/store request at a time and drives the dmem port (daddr, dwdata, we); the dmem returns drdata combinationally.
- The dmem commits at most one byte lane per clock, so this block serialises stores into one-hot lane writes.
- Splits misaligned accesses across two words and returns sign- or zero-extended load data.

Parameters:
- ADDR_W, 32, width of req_addr and daddr.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  illegal funct3, or misaligned access when trapping is enabled
- daddr  out  32  word-aligned memory address (bits [1:0] always 0)
- dwdata  out  32  write data, byte placed in its lane
- we  out  4  byte-lane write enable, at most one bit set
- drdata  in  32  memory read data, combinational from daddr

Behaviour:
- Reset (async, rst_n low): state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, daddr=0, dwdata=0, we=0.
  - Applies mid-operation: any in-flight transaction is discarded and remaining lanes are not written.
- Memory port outputs come from registers only; no combinational path from req_* to daddr/dwdata/we.
- States: IDLE, LD_LO, LD_HI, ST, RESP.
- IDLE: req_ready=1. On req_valid:
  - Latch op, funct3, addr and wdata.
  - Form an 8-bit byte mask over {hi word, lo word}: size (1/2/4) shifted by addr[1:0].
  - Lo word = addr & ~3. Hi word = lo word + 4, modulo 2^32 (wraps).
  - Transitions:
    - Illegal funct3 (3, 6, 7), any op: no memory access; go to RESP with rsp_err=1.
    - Load: go to LD_LO.
    - Store: go to ST.
- LD_LO: daddr = lo word; capture drdata at clock end.
  - If the mask touches the hi word, go to LD_HI; else go to RESP.
- LD_HI: daddr = hi word; capture drdata; go to RESP.
- Load extraction: concatenate {hi, lo}, shift right by 8*addr[1:0], take size bytes.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU; LW as-is.
- ST, one cycle per pending mask bit, lowest bit first:
  - daddr = lo word for mask bits [3:0], hi word for bits [7:4].
  - we = one-hot of the lane; dwdata = the byte in that lane, other lanes 0.
  - Clear the bit; when the mask is empty, go to RESP (we=0 in RESP).
- RESP: rsp_valid=1 with rsp_rdata and rsp_err stable; req_ready=0.
  - Transition to IDLE on rsp_ready.
- Latency, accept edge to rsp_valid:
  - Aligned load: 2 cycles; split load: 3 cycles.
  - Store: 1 + number of bytes (SB 2, SH 3, SW 5).
- A new request is accepted in the cycle after the response handshake; no overlap.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: any access with a hi-word byte set in the mask (LH/SH at addr[1:0]=3, LW/SW at addr[1:0]!=0) performs no memory access; go straight to RESP with rsp_err=1, rsp_rdata=0.
- Undefined: misaligned accesses are split across two words as described above; rsp_err is set only for illegal funct3.

Test Plan:
- SW 0x11223344 @0x10 -> ST cycles at daddr 0x10 with we 0001/0010/0100/1000 and lane bytes 44/33/22/11; rsp after 5 cycles. Then LW @0x10 -> rsp_rdata 0x11223344, 2 cycles after accept.
- SB 0x80 @0x13 -> single write, we=1000, dwdata=0x80000000. Then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080.
- Preload mem[0x17]=0x34, mem[0x18]=0x92; LH @0x17 -> daddr 0x14 then 0x18; rsp_rdata 0xFFFF9234, err=0. With the macro: no access, rsp_err=1.
- SW 0xAABBCCDD @0x0E -> writes 0xDD via we=0100 @0x0C, 0xCC via we=1000 @0x0C, 0xBB via we=0001 @0x10, 0xAA via we=0010 @0x10. LW @0x0E then returns 0xAABBCCDD.
- rsp_ready low for 3 cycles -> rsp_valid, rsp_rdata, rsp_err stable and req_ready=0. Request with funct3=3 -> rsp_err=1, we never asserted.
- rst_n low during SW after 2 lanes written -> we=0 immediately (asynchronous), state IDLE, rsp_valid=0; lanes 2 and 3 retain their old values.

Source files
------------

// File: rtl/lsu_dmem_port.sv
// Load/store unit initiator for the data-memory port: serialises stores into single-lane writes, splits misaligned accesses.
// Latency from the request-handshake cycle to rsp_valid: aligned load 2, split load 3, store 1+bytes, illegal funct3 1.
// One transaction in flight: req_ready only in IDLE; rsp_valid/rsp_rdata/rsp_err held until rsp_ready.
//
// Ports: clk/rst_n (async active-low); req_* request (valid/ready, we, funct3, addr, wdata);
//        rsp_* response (valid/ready, rdata, err); daddr/dwdata/we registered memory drive, drdata combinational return.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap (rsp_err=1, no access) any access touching the next word.
module lsu_dmem_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] daddr,
    output logic [DATA_W-1:0] dwdata,
    output logic [3:0]        we,
    input  logic [DATA_W-1:0] drdata
);

    typedef enum logic [2:0] {IDLE, LD_LO, LD_HI, ST, RESP} state_t;

    state_t              state;
    logic [2:0]          f3_q;
    logic [1:0]          off_q;
    logic [ADDR_W-1:0]   lo_q, hi_q;
    logic [7:0]          mask_q;      // pending byte lanes over {hi word, lo word}
    logic [63:0]         wide_q;      // store data pre-shifted into its lanes over {hi, lo}
    logic [DATA_W-1:0]   lo_data_q;

    // Request decode (only consumed in IDLE).
    logic [ADDR_W-1:0]   req_lo, req_hi;
    logic [3:0]          req_size;
    logic [7:0]          req_mask;
    logic [63:0]         req_wide;
    logic                req_legal, req_trap;

    assign req_lo   = {req_addr[ADDR_W-1:2], 2'b00};
    assign req_hi   = req_lo + ADDR_W'(4);          // wraps at the top of the address space
    assign req_mask = {4'b0000, req_size} << req_addr[1:0];
    assign req_wide = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};

    always_comb begin
        req_size = 4'b1111;
        case (req_funct3[1:0])
            2'd0:    req_size = 4'b0001;
            2'd1:    req_size = 4'b0011;
            default: req_size = 4'b1111;
        endcase
        req_legal = 1'b0;
        case (req_funct3)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: req_legal = 1'b1;
            default:                      req_legal = 1'b0;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        req_trap = |req_mask[7:4];
`else
        req_trap = 1'b0;
`endif
    end

    // Next store lane: taken from the incoming request in IDLE, else from the pending mask.
    logic [7:0]        st_src_mask, st_rem;
    logic [63:0]       st_src_wide;
    logic [ADDR_W-1:0] st_addr;
    logic [2:0]        st_idx;
    logic [7:0]        st_byte;
    logic [3:0]        st_we;
    logic [DATA_W-1:0] st_dat;

    always_comb begin
        st_src_mask = (state == IDLE) ? req_mask : mask_q;
        st_src_wide = (state == IDLE) ? req_wide : wide_q;
        st_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (st_src_mask[i]) st_idx = 3'(i);
        end
        if (state == IDLE) st_addr = st_idx[2] ? req_hi : req_lo;
        else               st_addr = st_idx[2] ? hi_q : lo_q;
        st_byte = st_src_wide[{st_idx, 3'b000} +: 8];
        st_we   = 4'b0001 << st_idx[1:0];
        st_dat  = DATA_W'(st_byte) << {st_idx[1:0], 3'b000};
        st_rem  = st_src_mask & ~(8'b0000_0001 << st_idx);
    end

    // Align the {hi, lo} pair to the access offset, then extend per width code.
    function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [63:0] sh;
        sh = pair >> {off, 3'b000};
        case (f3)
            3'd0:    extract = {{24{sh[7]}}, sh[7:0]};
            3'd1:    extract = {{16{sh[15]}}, sh[15:0]};
            3'd4:    extract = {24'b0, sh[7:0]};
            3'd5:    extract = {16'b0, sh[15:0]};
            default: extract = sh[31:0];
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            daddr     <= '0;
            dwdata    <= '0;
            we        <= 4'b0000;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            lo_q      <= '0;
            hi_q      <= '0;
            mask_q    <= 8'd0;
            wide_q    <= 64'd0;
            lo_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        f3_q      <= req_funct3;
                        off_q     <= req_addr[1:0];
                        lo_q      <= req_lo;
                        hi_q      <= req_hi;
                        wide_q    <= req_wide;
                        req_ready <= 1'b0;
                        if (!req_legal || req_trap) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (req_we) begin
                            // First lane is presented straight away so every ST cycle writes one byte.
                            daddr  <= st_addr;
                            we     <= st_we;
                            dwdata <= st_dat;
                            mask_q <= st_rem;
                            state  <= ST;
                        end else begin
                            daddr  <= req_lo;
                            mask_q <= req_mask;
                            state  <= LD_LO;
                        end
                    end
                end
                LD_LO: begin
                    if (|mask_q[7:4]) begin
                        lo_data_q <= drdata;
                        daddr     <= hi_q;
                        state     <= LD_HI;
                    end else begin
                        rsp_rdata <= extract({32'b0, drdata}, off_q, f3_q);
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                LD_HI: begin
                    rsp_rdata <= extract({drdata, lo_data_q}, off_q, f3_q);
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                ST: begin
                    if (mask_q == 8'd0) begin
                        we        <= 4'b0000;
                        dwdata    <= '0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        daddr  <= st_addr;
                        we     <= st_we;
                        dwdata <= st_dat;
                        mask_q <= st_rem;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
